fsm_ctrl_driver: RTL and testbench

- Transmit-side partner of the 4-state ctrl-level sequencer: IDLE(Y=00) -> START(01) -> STOP(10) -> CLEAR(11) -> IDLE.
- That sequencer advances one state per required ctrl level: 1, 0, 1, 0 in turn. This block accepts a target Y code over a valid/ready handshake and toggles ctrl the required number of times to reach it.
- Each ctrl level is held for HOLD cycles.
- The sequencer's Y is fed back, checked after every step, and any mismatch is flagged.

---
 rtl/fsm_ctrl_pkg.sv | 23 ++
 rtl/fsm_ctrl_driver_hold_timer.sv | 28 ++
 rtl/fsm_ctrl_driver.sv | 117 +++++++++++
 tb/tb_fsm_ctrl_driver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_ctrl_pkg.sv
// Shared codes and driver state encoding for the ctrl-level sequencer and its driver.
// The sequencer advances one code per required ctrl level; codes only ever move forward.
package fsm_ctrl_pkg;

  typedef logic [1:0] code_t;

  localparam code_t Y_IDLE  = 2'b00;
  localparam code_t Y_START = 2'b01;
  localparam code_t Y_STOP  = 2'b10;
  localparam code_t Y_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } drv_state_t;

  // Next code in the IDLE -> START -> STOP -> CLEAR -> IDLE ring.
  function automatic code_t next_code(input code_t c);
    return code_t'(c + 2'd1);
  endfunction

endpackage

// File: rtl/fsm_ctrl_driver_hold_timer.sv
// Down-counter timing how long each ctrl level is held; load wins over decrement.
// Saturates at zero; zero flag is combinational from the count register.
module hold_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fsm_ctrl_driver.sv
// Drives ctrl toggles to walk the sequencer to a requested code, verifying y_obs after each step.
// N-step request completes N*HOLD+1 cycles after acceptance; req_ready low until back in idle.
module fsm_ctrl_driver
  import fsm_ctrl_pkg::*;
#(
  parameter int HOLD  = 2,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_target,
  output logic       req_ready,
  input  logic [1:0] y_obs,
  output logic       ctrl,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       err_clr,
  output logic [1:0] cur_code
);

  // HOLD must stay >= 2 so the sequencer's registered Y has settled by sample time.
  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD - 1);

  drv_state_t state, state_nxt;
  code_t      target_q;
  code_t      exp_code;
  logic       accept;
  logic       same_code;
  logic       sample;
  logic       step_ok;
  logic       step_bad;
  logic       last_step;
  logic       toggle;
  logic       tmr_zero;

  assign accept    = req_valid && (state == S_IDLE);
  assign same_code = (req_target == cur_code);
  assign exp_code  = next_code(cur_code);
  assign sample    = (state == S_STEP) && tmr_zero;
  assign step_ok   = sample && (y_obs == exp_code);
  assign step_bad  = sample && (y_obs != exp_code);
  assign last_step = (exp_code == target_q);
  assign toggle    = (accept && !same_code) || (step_ok && !last_step);

  hold_timer #(
    .CNT_W(CNT_W)
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (toggle),
    .load_val (HOLD_RELOAD),
    .dec      (state == S_STEP),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = same_code ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        if (step_bad || (step_ok && last_step)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state == S_STEP);
    done      = (state == S_DONE);
  end

  // On a mismatch cur_code resyncs to what the sequencer actually reports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl     <= 1'b0;
      cur_code <= Y_IDLE;
      target_q <= Y_IDLE;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        target_q <= req_target;
      end
      if (toggle) begin
        ctrl <= ~ctrl;
      end
      if (step_ok) begin
        cur_code <= exp_code;
      end else if (step_bad) begin
        cur_code <= y_obs;
      end
      if (step_bad) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fsm_ctrl_driver.sv
// Bench for fsm_ctrl_driver: real sequencer model on y_obs, optional y_obs fault injection,
// transaction-level reference predicting per-cycle ctrl/code/busy/done from step arithmetic.
module tb_fsm_ctrl_driver;

  localparam int HOLD  = 2;
  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_target;
  logic       req_ready;
  logic [1:0] y_obs;
  logic       ctrl;
  logic       busy;
  logic       done;
  logic       err;
  logic       err_clr;
  logic [1:0] cur_code;

  logic [1:0] seq_y;
  logic       force_en;
  logic [1:0] force_val;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_code;
  int m_ctrl;
  int m_err;

  always #5 clk = ~clk;

  // Driven sequencer: advances one code per cycle while ctrl is at the level the current code needs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_y <= 2'b00;
    end else if (ctrl != seq_y[0]) begin
      seq_y <= seq_y + 2'd1;
    end
  end

  assign y_obs = force_en ? force_val : seq_y;

  fsm_ctrl_driver #(
    .HOLD  (HOLD),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_target (req_target),
    .req_ready  (req_ready),
    .y_obs      (y_obs),
    .ctrl       (ctrl),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_clr    (err_clr),
    .cur_code   (cur_code)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = 1'b0;
    req_target = 2'b00;
    err_clr   = 1'b0;
    force_en  = 1'b0;
    force_val = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_code = 0;
    m_ctrl = 0;
    m_err  = 0;
    chk("rst_ctrl", ctrl, 0);
    chk("rst_code", cur_code, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
  endtask

  // Issue one request from a negedge; fault_step<0 means no fault injection.
  task automatic do_req(input int tgt, input int fault_step, input int fault_val, input bit clr_at_fault);
    int c, n, fs, toggles, done_cyc, fin_code, fin_err, nt, exp_code;
    c  = m_code;
    n  = (tgt - c + 4) % 4;
    fs = fault_step;
    if (fs >= 0 && fs < n) begin
      toggles  = fs + 1;
      done_cyc = toggles * HOLD + 1;
      fin_code = fault_val & 3;
      fin_err  = 1;
    end else begin
      fs       = -1;
      toggles  = n;
      done_cyc = (n == 0) ? 1 : n * HOLD + 1;
      fin_code = tgt & 3;
      fin_err  = m_err;
    end
    chk("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_target = 2'(tgt);
    for (int k = 1; k <= 4 * HOLD + 4; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      force_en  = (fs >= 0) && (k == (fs + 1) * HOLD);
      force_val = 2'(fault_val);
      err_clr   = force_en && clr_at_fault;
      nt = (k - 1) / HOLD + 1;
      if (nt > toggles) nt = toggles;
      exp_code = (k >= done_cyc) ? fin_code : (c + (k - 1) / HOLD) % 4;
      chk($sformatf("ctrl@%0d", k), ctrl, (m_ctrl + nt) % 2);
      chk($sformatf("code@%0d", k), cur_code, exp_code);
      chk($sformatf("busy@%0d", k), busy, (k < done_cyc) ? 1 : 0);
      chk($sformatf("done@%0d", k), done, (k == done_cyc) ? 1 : 0);
      chk($sformatf("ready@%0d", k), req_ready, 0);
      if (k == done_cyc) begin
        chk("err_at_done", err, fin_err);
        break;
      end
    end
    @(negedge clk);
    chk("done_after", done, 0);
    chk("ready_after", req_ready, 1);
    chk("ctrl_after", ctrl, (m_ctrl + toggles) % 2);
    m_code = fin_code;
    m_ctrl = (m_ctrl + toggles) % 2;
    m_err  = fin_err;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr_alone", err, 0);
    m_err = 0;
  endtask

  initial begin
    reset = 1'b0;
    do_reset();

    do_req(3, -1, 0, 1'b0);   // 00 -> 11, three steps
    do_req(1, -1, 0, 1'b0);   // 11 -> 01, wraps through 00
    do_req(2, -1, 0, 1'b0);   // 01 -> 10
    do_req(2, -1, 0, 1'b0);   // zero-step
    chk("seq_tracks", seq_y, 2);

    // First-step mismatch: observe 00 while 01 expected
    do_reset();
    do_req(3, 0, 0, 1'b0);
    chk("fault_err", err, 1);
    chk("fault_code", cur_code, 0);
    repeat (3) @(negedge clk);
    chk("no_second_toggle", ctrl, 1);
    clear_err();

    // err_clr coincident with a new mismatch loses
    do_reset();
    do_req(2, 1, 0, 1'b1);
    chk("clr_vs_err", err, 1);
    clear_err();

    // Reset mid-request aborts asynchronously
    do_reset();
    req_valid  = 1'b1;
    req_target = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_ctrl", ctrl, 0);
    chk("abort_code", cur_code, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_busy", busy, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done_rst", done, 0);
    end
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", req_ready, 1);
    end
    m_code = 0;
    m_ctrl = 0;
    m_err  = 0;

    for (int it = 0; it < 60; it++) begin
      int tgt, fstep, fval;
      bit fclr;
      tgt   = int'($urandom_range(0, 3));
      fstep = -1;
      fval  = 0;
      fclr  = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        fstep = int'($urandom_range(0, 2));
        fval  = (m_code + fstep + 1 + int'($urandom_range(1, 3))) % 4;
        fclr  = 1'($urandom_range(0, 1));
      end
      do_req(tgt, fstep, fval, fclr);
      if (m_err != 0) begin
        if ($urandom_range(0, 1) == 1) clear_err();
        do_reset();
      end else begin
        chk("rand_seq_sync", seq_y, m_code);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
